// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// default reset/exception addresses and the word increment.
package pc_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      HOLD  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
   localparam logic [31:0] PC_INCR        = 32'd4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and memory (slave).
// Handshake: master raises imemReq with imemAddr and keeps the address stable
// until a cycle with imemAck=1; imemData is valid only in that ack cycle.
interface pc_fetch_ctrl_if;

   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemAck,
      input  imemData
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemAck,
      output imemData
   );

endinterface

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Next fetch address selector: exception > branch > jump > sequential (+4).
// o_redirect flags that a non-sequential target won.
module next_pc_sel
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic [31:0] i_cur_pc,
   input  logic        i_exception,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_jump,
   input  logic [31:0] i_jump_target,
   output logic [31:0] o_next_pc,
   output logic        o_redirect
);

   logic [31:0] w_seq_pc;

   assign w_seq_pc   = i_cur_pc + PC_INCR;
   assign o_redirect = i_exception | i_branch_taken | i_jump;

   always_comb begin
      o_next_pc = w_seq_pc;
      if (i_exception) begin
         o_next_pc = EXC_VECTOR;
      end else if (i_branch_taken) begin
         o_next_pc = i_branch_target;
      end else if (i_jump) begin
         o_next_pc = i_jump_target;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: issues instruction-memory requests,
// registers returned words for decode and handles redirects and stalls.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  stall,
   input  logic                  exception,
   input  logic                  branchTaken,
   input  logic [31:0]           branchTarget,
   input  logic                  jump,
   input  logic [31:0]           jumpTarget,
   pc_fetch_ctrl_if.master       imem,
   output logic [31:0]           instr,
   output logic                  instrValid,
   output logic [31:0]           instrPC,
   output logic [31:0]           pcPlusFour,
   output fetch_state_e          dbgState
);

   fetch_state_e r_state, w_state_nxt;
   logic [31:0]  r_addr, w_addr_nxt;
   logic [31:0]  r_instr, w_instr_nxt;
   logic [31:0]  r_instr_pc, w_instr_pc_nxt;
   logic         r_valid, w_valid_nxt;
   logic [31:0]  r_pending, w_pending_nxt;
   logic         w_req;
   logic [31:0]  w_next_pc;
   logic         w_redirect;

   next_pc_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc_sel (
      .i_cur_pc        (r_addr),
      .i_exception     (exception),
      .i_branch_taken  (branchTaken),
      .i_branch_target (branchTarget),
      .i_jump          (jump),
      .i_jump_target   (jumpTarget),
      .o_next_pc       (w_next_pc),
      .o_redirect      (w_redirect)
   );

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state    <= BOOT;
         r_addr     <= RESET_PC;
         r_instr    <= 32'h0000_0000;
         r_instr_pc <= RESET_PC;
         r_valid    <= 1'b0;
         r_pending  <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_instr    <= w_instr_nxt;
         r_instr_pc <= w_instr_pc_nxt;
         r_valid    <= w_valid_nxt;
         r_pending  <= w_pending_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_instr_nxt    = r_instr;
      w_instr_pc_nxt = r_instr_pc;
      w_valid_nxt    = r_valid;
      w_pending_nxt  = r_pending;
      w_req          = 1'b0;
      case (r_state)
         BOOT: begin
            w_addr_nxt  = RESET_PC;
            w_state_nxt = FETCH;
         end
         FETCH: begin
            w_req = 1'b1;
            if (w_redirect) begin
               w_valid_nxt = 1'b0;
               if (imem.imemAck) begin
                  w_addr_nxt = w_next_pc;
               end else begin
                  w_pending_nxt = w_next_pc;
                  w_state_nxt   = FLUSH;
               end
            end else if (imem.imemAck) begin
               w_instr_nxt    = imem.imemData;
               w_instr_pc_nxt = r_addr;
               w_valid_nxt    = 1'b1;
               w_addr_nxt     = w_next_pc;
               if (stall) begin
                  w_state_nxt = HOLD;
               end
            end else if (!stall) begin
               // Decode consumed the presented word and nothing new arrived.
               w_valid_nxt = 1'b0;
            end
         end
         FLUSH: begin
            w_req = 1'b1;
            if (w_redirect) begin
               w_pending_nxt = w_next_pc;
            end
            if (imem.imemAck) begin
               w_addr_nxt  = w_redirect ? w_next_pc : r_pending;
               w_state_nxt = FETCH;
            end
         end
         HOLD: begin
            if (w_redirect) begin
               w_valid_nxt = 1'b0;
               w_addr_nxt  = w_next_pc;
               w_state_nxt = FETCH;
            end else if (!stall) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = FETCH;
            end
         end
         default: begin
            w_state_nxt = BOOT;
         end
      endcase
   end

   assign imem.imemReq  = w_req;
   assign imem.imemAddr = r_addr;
   assign instr         = r_instr;
   assign instrValid    = r_valid;
   assign instrPC       = r_instr_pc;
   assign pcPlusFour    = r_instr_pc + PC_INCR;
   assign dbgState      = r_state;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_0080, the exception redirect target.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rstN  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  downstream hold; the current instruction is not consumed.
REQ-006 exception  input  1  redirect to EXC_VECTOR.
REQ-007 branchTaken  input  1  redirect to branchTarget.
REQ-008 branchTarget  input  32  branch destination.
REQ-009 jump  input  1  redirect to jumpTarget.
REQ-010 jumpTarget  input  32  jump destination.
REQ-011 imemReq  output  1  fetch request to instruction memory.
REQ-012 imemAddr  output  32  fetch address.
REQ-013 imemAck  input  1  memory response; imemData is valid this cycle.
REQ-014 imemData  input  32  fetched instruction word.
REQ-015 instr  output  32  registered instruction to decode.
REQ-016 instrValid  output  1  instr and instrPC are valid.
REQ-017 instrPC  output  32  address of instr.
REQ-018 pcPlusFour  output  32  instrPC + 4, for link and branch-offset use.

Function
REQ-019 SHALL implement the states BOOT, FETCH, FLUSH and HOLD.
REQ-020 BOOT: imemReq=0; go unconditionally to FETCH with imemAddr=RESET_PC.
REQ-021 FETCH: imemReq=1; imemAddr SHALL stay stable until the cycle in which imemAck=1.
REQ-022 FETCH with imemAck=1 and no redirect: instr<=imemData, instrPC<=imemAddr, instrValid<=1, imemAddr<=imemAddr+4.
  - if stall=0, stay in FETCH.
  - if stall=1, go to HOLD.
REQ-023 Redirect selection SHALL use priority exception > branchTaken > jump; the selected target is called the redirect target.
REQ-024 Redirect in FETCH with imemAck=1: discard imemData; instrValid<=0; imemAddr<=redirect target; stay in FETCH.
REQ-025 Redirect in FETCH with imemAck=0: latch the redirect target into a pending register; go to FLUSH.
REQ-026 FLUSH: imemReq=1 with the old address held, and instrValid=0.
  - On imemAck=1, discard the data, set imemAddr<=pending target, go to FETCH.
  - A further redirect in FLUSH SHALL overwrite the pending target, subject to the REQ-023 priority within that cycle.
REQ-027 HOLD: imemReq=0; instr, instrPC and instrValid held.
  - On stall=0 with no redirect, go to FETCH.
  - On any redirect, regardless of stall, set instrValid<=0, imemAddr<=redirect target, go to FETCH.
REQ-028 In FETCH, any redirect SHALL clear instrValid on the next edge, so a killed instruction is never presented.
REQ-029 Address arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-030 Redirect targets SHALL be used as given; bits [1:0] are not checked or masked.
REQ-031 pcPlusFour SHALL be combinational, equal to instrPC+4.
REQ-032 If stall=1 in FETCH while instrValid=1 and no ack arrives, instr SHALL hold; the next ack is then registered and goes to HOLD per REQ-022.

Reset
REQ-033 While rstN=0, the block SHALL be in BOOT with these values:
  - imemReq=0, imemAddr=RESET_PC.
  - instr=32'h0000_0000, instrPC=RESET_PC, instrValid=0.
  - pending target=RESET_PC.
REQ-034 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imemAck after reset release, while in BOOT, SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold the state encoding (2-bit enum BOOT/FETCH/FLUSH/HOLD), RESET_PC, EXC_VECTOR and the word-increment constant 4.
REQ-036 Next-address selection SHALL be a sub-module, next_pc_sel: a combinational priority selector over sequential, jump, branch and exception, instantiated once.

Verification
REQ-037 Reset release, imemAck=1 every cycle, stall=0:
  - imemAddr reads 0x0, 0x4, 0x8.
  - instrValid rises two cycles after release, with instrPC=0x0.
REQ-038 Ack at 0x8 with jump=1, jumpTarget=0x400 in the same cycle:
  - next imemAddr=0x400.
  - the 0x8 data is never presented, and instrValid=0 for one cycle.
REQ-039 exception=1, branchTaken=1 and jump=1 in the same cycle -> next imemAddr=0x80.
REQ-040 Ack held low at 0x10, branchTaken=1 with target 0x200, ack arrives three cycles later:
  - imemAddr stays 0x10 until the ack.
  - that data is discarded, then imemAddr=0x200.
REQ-041 stall=1 for four cycles after instr 0x20 is presented:
  - instr and instrPC=0x20 are held, and imemReq=0 in HOLD.
  - after stall drops, fetch resumes at 0x24.
REQ-042 Fetch at 0xFFFF_FFFC acked -> next imemAddr=0x0; also drive rstN=0 mid-FLUSH -> outputs equal the REQ-033 values immediately, without waiting for a clock edge.
